counter_read_latch: RTL and testbench
=====================================

Name: counter_read_latch

Overview:
Read-side output latch for one 8254 counter; directly downstream of the counting element. Tracks the live 16-bit current_count, freezes it on a Counter Latch command, and serves it to the data bus as bytes according to the RW access mode, with an LSB/MSB byte pointer. Optionally latches an 8-bit status byte for Read-Back and returns it ahead of count bytes.

Parameters:
- COUNT_W, 16, width of current_count and the output latch (OL).
- DATA_W, 8, data bus byte width. COUNT_W must equal 2*DATA_W.

Ports:
- CLK  in  1  single system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- current_count  in  16  live count from the counting element.
- RW  in  2  access mode: 01 LSB only, 10 MSB only, 11 LSB then MSB, 00 reserved.
- counter_programmed  in  1  1-cycle pulse when a new control word is written to this counter.
- latch_cmd  in  1  1-cycle Counter Latch command pulse.
- status_latch_cmd  in  1  1-cycle Read-Back status latch pulse.
- status_in  in  8  status byte {OUT, null_count, RW[1:0], mode[2:0], BCD}.
- read_strobe  in  1  1-cycle CPU read pulse.
- data_out  out  8  registered read byte.
- data_valid  out  1  pulse, 1 cycle after read_strobe.
- count_latched  out  1  OL frozen and awaiting read.
- status_latched  out  1  status byte held and awaiting read.

Behaviour:
- Reset (async): OL=16'h0000, status_reg=8'h00, count_latched=0, status_latched=0, byte_ptr=0, data_out=8'h00, data_valid=0.
- OL tracking: when count_latched=0, OL <= current_count every cycle, so OL lags current_count by one cycle.
- latch_cmd with count_latched=0: OL <= current_count that cycle; count_latched=1. latch_cmd with count_latched=1 is ignored and OL is unchanged.
- status_latch_cmd with status_latched=0: status_reg <= status_in; status_latched=1. Repeated commands are ignored until the status byte is read.
- Read decode on read_strobe, using register state at the start of the cycle:
  - If status_latched=1: data_out=status_reg and status_latched clears. byte_ptr and count_latched are unchanged.
  - Else RW=01: data_out=OL[7:0]; count_latched clears.
  - Else RW=10: data_out=OL[15:8]; count_latched clears.
  - Else RW=11, byte_ptr=0: data_out=OL[7:0]; byte_ptr becomes 1.
  - Else RW=11, byte_ptr=1: data_out=OL[15:8]; byte_ptr becomes 0; count_latched clears.
  - Else RW=00: data_out=8'h00; no state change.
- Latency: data_out and data_valid update on the edge that samples read_strobe. data_valid is high exactly one cycle. data_out holds its value between reads.
- count_latched clears only when the read sequence for the current RW is complete. A lone LSB read in mode 11 keeps the latch.
- latch_cmd and a completing read in the same cycle: the read returns the old OL byte; latch_cmd then freezes the new current_count and count_latched stays 1.
- status_latch_cmd and a status read in the same cycle: the old status is returned; the new status is captured and status_latched stays 1.
- counter_programmed has the highest priority. It clears count_latched, status_latched and byte_ptr, and in that same cycle it suppresses latch_cmd, status_latch_cmd and the state effects of read_strobe. data_valid still pulses, with data_out=8'h00.
- A change of RW without counter_programmed does not reset byte_ptr.

Optional Feature:
- Macro: READBACK_STATUS_EN.
- Defined: status latch path as described above.
- Undefined: status_reg is absent, status_latched is tied to 0, and status_latch_cmd and status_in are ignored. Reads always return count bytes.

Test Plan:
- Reset mid-operation: assert RESET while count_latched=1 -> all outputs and state return to reset values immediately, with no clock edge needed.
- RW=11, current_count=16'h1234, then latch_cmd; current_count moves to 16'h1200; two reads -> data_out=8'h34 then 8'h12; count_latched drops after the 2nd read; OL then tracks 16'h1200.
- RW=01, latch_cmd at 16'h00A5; second latch_cmd at 16'h00A0; one read -> data_out=8'hA5 (second latch ignored); count_latched=0.
- Status latch (macro on): status_in=8'hB6, status_latch_cmd, then latch_cmd at 16'hBEEF, RW=11; three reads -> 8'hB6, 8'hEF, 8'hBE. Macro off: same stimulus -> 8'hEF, 8'hBE.
- RW=11: one read gives LSB 8'h34, then counter_programmed pulse; next read after latch of 16'h5678 -> 8'h78 (byte_ptr reset).
- Simultaneous: RW=10, OL latched at 16'hAB00, read_strobe and latch_cmd in the same cycle with current_count=16'hCD00 -> data_out=8'hAB; count_latched=1; next read -> 8'hCD.

Source files
------------

// File: rtl/counter_read_latch.sv
// Read-side output latch for one 8254 counter: tracks/freezes the count and serves it bytewise.
// Optional Read-Back status path enabled by defining READBACK_STATUS_EN.
module counter_read_latch #(
   parameter int unsigned COUNT_W = 16,
   parameter int unsigned DATA_W  = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [COUNT_W-1:0] current_count,
   input  logic [1:0]         RW,
   input  logic               counter_programmed,
   input  logic               latch_cmd,
   input  logic               status_latch_cmd,
   input  logic [DATA_W-1:0]  status_in,
   input  logic               read_strobe,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_valid,
   output logic               count_latched,
   output logic               status_latched
);

   logic [COUNT_W-1:0] out_latch;
   logic               byte_ptr;
   logic [DATA_W-1:0]  status_byte;

   logic [DATA_W-1:0]  byte_sel;
   logic               byte_ptr_nxt;
   logic               rd_done;
   logic               status_rd;
   logic               rd_eff;
   logic               latch_ok;

   assign rd_eff = read_strobe & ~counter_programmed;

   // Read decode uses register state at the start of the cycle; status byte takes precedence.
   always_comb begin
      byte_sel     = '0;
      byte_ptr_nxt = byte_ptr;
      rd_done      = 1'b0;
      status_rd    = 1'b0;
      if (status_latched) begin
         byte_sel  = status_byte;
         status_rd = 1'b1;
      end else begin
         case (RW)
            2'b01: begin
               byte_sel = out_latch[DATA_W-1:0];
               rd_done  = 1'b1;
            end
            2'b10: begin
               byte_sel = out_latch[COUNT_W-1:DATA_W];
               rd_done  = 1'b1;
            end
            2'b11: begin
               if (!byte_ptr) begin
                  byte_sel     = out_latch[DATA_W-1:0];
                  byte_ptr_nxt = 1'b1;
               end else begin
                  byte_sel     = out_latch[COUNT_W-1:DATA_W];
                  byte_ptr_nxt = 1'b0;
                  rd_done      = 1'b1;
               end
            end
            default: begin
               byte_sel = '0;
            end
         endcase
      end
   end

   // A completing read frees the latch in the same cycle, so a coincident latch_cmd is honoured.
   assign latch_ok = latch_cmd & ~counter_programmed & (~count_latched | (rd_eff & rd_done));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         out_latch     <= '0;
         count_latched <= 1'b0;
         byte_ptr      <= 1'b0;
         data_out      <= '0;
         data_valid    <= 1'b0;
      end else begin
         if (latch_ok || !count_latched) begin
            out_latch <= current_count;
         end

         if (counter_programmed) begin
            count_latched <= 1'b0;
         end else if (latch_ok) begin
            count_latched <= 1'b1;
         end else if (rd_eff && rd_done) begin
            count_latched <= 1'b0;
         end

         if (counter_programmed) begin
            byte_ptr <= 1'b0;
         end else if (rd_eff) begin
            byte_ptr <= byte_ptr_nxt;
         end

         data_valid <= read_strobe;
         if (read_strobe) begin
            data_out <= counter_programmed ? '0 : byte_sel;
         end
      end
   end

`ifdef READBACK_STATUS_EN
   logic [DATA_W-1:0] status_reg;
   logic              status_ok;

   assign status_ok   = status_latch_cmd & ~counter_programmed &
                        (~status_latched | (rd_eff & status_rd));
   assign status_byte = status_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         status_reg     <= '0;
         status_latched <= 1'b0;
      end else begin
         if (status_ok) begin
            status_reg <= status_in;
         end
         if (counter_programmed) begin
            status_latched <= 1'b0;
         end else if (status_ok) begin
            status_latched <= 1'b1;
         end else if (rd_eff && status_rd) begin
            status_latched <= 1'b0;
         end
      end
   end
`else
   logic unused_status;

   assign unused_status  = ^{status_latch_cmd, status_in};
   assign status_byte    = '0;
   assign status_latched = 1'b0;
`endif

endmodule

// File: tb/tb_counter_read_latch.sv
// Directed self-checking bench for counter_read_latch; expectations follow READBACK_STATUS_EN.
module tb_counter_read_latch;

   logic        CLK;
   logic        RESET;
   logic [15:0] current_count;
   logic [1:0]  RW;
   logic        counter_programmed;
   logic        latch_cmd;
   logic        status_latch_cmd;
   logic [7:0]  status_in;
   logic        read_strobe;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        count_latched;
   logic        status_latched;

   int n_checks = 0;
   int n_fail   = 0;

   counter_read_latch dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .current_count     (current_count),
      .RW                (RW),
      .counter_programmed(counter_programmed),
      .latch_cmd         (latch_cmd),
      .status_latch_cmd  (status_latch_cmd),
      .status_in         (status_in),
      .read_strobe       (read_strobe),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .count_latched     (count_latched),
      .status_latched    (status_latched)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge, sample just after it, then drop all pulse inputs.
   task automatic cyc();
      @(posedge CLK);
      #1;
      latch_cmd          = 1'b0;
      status_latch_cmd   = 1'b0;
      read_strobe        = 1'b0;
      counter_programmed = 1'b0;
   endtask

   initial begin
      RESET              = 1'b1;
      current_count      = 16'h0000;
      RW                 = 2'b11;
      counter_programmed = 1'b0;
      latch_cmd          = 1'b0;
      status_latch_cmd   = 1'b0;
      status_in          = 8'h00;
      read_strobe        = 1'b0;
      cyc();
      cyc();
      check("rst_data_out", {8'h00, data_out}, 16'h0000);
      check("rst_valid", {15'h0, data_valid}, 16'h0000);
      check("rst_count_latched", {15'h0, count_latched}, 16'h0000);
      check("rst_status_latched", {15'h0, status_latched}, 16'h0000);
      RESET = 1'b0;

      // RW=11 latch 1234, count moves on, two reads.
      current_count = 16'h1234;
      cyc();
      latch_cmd = 1'b1;
      cyc();
      check("m11_latched", {15'h0, count_latched}, 16'h0001);
      current_count = 16'h1200;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("m11_lsb", {8'h00, data_out}, 16'h0034);
      check("m11_valid", {15'h0, data_valid}, 16'h0001);
      check("m11_keep_latch", {15'h0, count_latched}, 16'h0001);
      cyc();
      check("m11_valid_pulse", {15'h0, data_valid}, 16'h0000);
      check("m11_hold", {8'h00, data_out}, 16'h0034);
      read_strobe = 1'b1;
      cyc();
      check("m11_msb", {8'h00, data_out}, 16'h0012);
      check("m11_cleared", {15'h0, count_latched}, 16'h0000);
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("m11_track_lsb", {8'h00, data_out}, 16'h0000);
      read_strobe = 1'b1;
      cyc();
      check("m11_track_msb", {8'h00, data_out}, 16'h0012);

      // Async reset mid-read leaves no partial state.
      current_count = 16'h4321;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("pre_rst_lsb", {8'h00, data_out}, 16'h0021);
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_latched", {15'h0, count_latched}, 16'h0000);
      check("async_rst_data", {8'h00, data_out}, 16'h0000);
      check("async_rst_valid", {15'h0, data_valid}, 16'h0000);
      cyc();
      RESET = 1'b0;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("post_rst_ptr", {8'h00, data_out}, 16'h0021);
      read_strobe = 1'b1;
      cyc();
      check("post_rst_msb", {8'h00, data_out}, 16'h0043);

      // RW=01: second latch ignored.
      RW = 2'b01;
      current_count = 16'h00A5;
      latch_cmd = 1'b1;
      cyc();
      current_count = 16'h00A0;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("m01_first_latch", {8'h00, data_out}, 16'h00A5);
      check("m01_cleared", {15'h0, count_latched}, 16'h0000);

      // Status byte ahead of count bytes.
      RW = 2'b11;
      status_in = 8'hB6;
      status_latch_cmd = 1'b1;
      cyc();
      status_in = 8'h11;
      status_latch_cmd = 1'b1;
      cyc();
      current_count = 16'hBEEF;
      latch_cmd = 1'b1;
      cyc();
      current_count = 16'h0000;
`ifdef READBACK_STATUS_EN
      check("st_latched", {15'h0, status_latched}, 16'h0001);
      read_strobe = 1'b1;
      cyc();
      check("st_byte", {8'h00, data_out}, 16'h00B6);
      check("st_cleared", {15'h0, status_latched}, 16'h0000);
      check("st_count_kept", {15'h0, count_latched}, 16'h0001);
`else
      check("st_absent", {15'h0, status_latched}, 16'h0000);
`endif
      read_strobe = 1'b1;
      cyc();
      check("st_lsb", {8'h00, data_out}, 16'h00EF);
      read_strobe = 1'b1;
      cyc();
      check("st_msb", {8'h00, data_out}, 16'h00BE);

`ifdef READBACK_STATUS_EN
      // Status read and new status latch in the same cycle.
      status_in = 8'hB6;
      status_latch_cmd = 1'b1;
      cyc();
      status_in = 8'hC3;
      status_latch_cmd = 1'b1;
      read_strobe = 1'b1;
      cyc();
      check("st_same_old", {8'h00, data_out}, 16'h00B6);
      check("st_same_held", {15'h0, status_latched}, 16'h0001);
      read_strobe = 1'b1;
      cyc();
      check("st_same_new", {8'h00, data_out}, 16'h00C3);
`endif

      // counter_programmed resets byte pointer and blanks a coincident read.
      current_count = 16'h1234;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("prog_lsb", {8'h00, data_out}, 16'h0034);
      counter_programmed = 1'b1;
      read_strobe = 1'b1;
      latch_cmd = 1'b1;
      cyc();
      check("prog_zero", {8'h00, data_out}, 16'h0000);
      check("prog_valid", {15'h0, data_valid}, 16'h0001);
      check("prog_unlatched", {15'h0, count_latched}, 16'h0000);
      current_count = 16'h5678;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("prog_ptr_reset", {8'h00, data_out}, 16'h0078);

      // RW change without programming keeps byte_ptr=1.
      RW = 2'b01;
      read_strobe = 1'b1;
      cyc();
      check("rw_chg_lsb", {8'h00, data_out}, 16'h0078);
      RW = 2'b11;
      current_count = 16'h9ABC;
      latch_cmd = 1'b1;
      cyc();
      read_strobe = 1'b1;
      cyc();
      check("rw_chg_ptr_kept", {8'h00, data_out}, 16'h009A);

      // RW=10: coincident read and latch.
      RW = 2'b10;
      current_count = 16'hAB00;
      latch_cmd = 1'b1;
      cyc();
      current_count = 16'hCD00;
      cyc();
      read_strobe = 1'b1;
      latch_cmd = 1'b1;
      cyc();
      check("sim_old", {8'h00, data_out}, 16'h00AB);
      check("sim_relatched", {15'h0, count_latched}, 16'h0001);
      current_count = 16'hEE00;
      read_strobe = 1'b1;
      cyc();
      check("sim_new", {8'h00, data_out}, 16'h00CD);
      check("sim_cleared", {15'h0, count_latched}, 16'h0000);

      // Reserved RW returns zero.
      RW = 2'b00;
      read_strobe = 1'b1;
      cyc();
      check("rw00_zero", {8'h00, data_out}, 16'h0000);
      check("rw00_valid", {15'h0, data_valid}, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
